tcsr_multi: RTL and testbench
=============================

TCSR_MULTI -- requirements
Module: tcsr_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of compare-match channels (legal 1..7).
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the bus data width; elaboration SHALL fail unless 2*NUM_CH+1 <= DATA_W.
REQ-003 The block SHALL have parameter IRQ_PULSE, default 0, selecting the interrupt mode: 0 = level, 1 = single-cycle pulse.
REQ-004 The block SHALL have port i_clk_sys, input, 1 bit: system clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_wren, input, 1 bit: bus write strobe, single-cycle qualified.
REQ-007 The block SHALL have port i_addr, input, 2 bits: register select (0 CTRL, 1 STAT, 2 IE, 3 OVR).
REQ-008 The block SHALL have port i_wdata, input, DATA_W bits: bus write data.
REQ-009 The block SHALL have port o_rdata, output, DATA_W bits: combinational read of the register selected by i_addr.
REQ-010 The block SHALL have port i_overflow, input, 1 bit: counter overflow event pulse.
REQ-011 The block SHALL have port i_cm, input, NUM_CH bits: per-channel compare-match event pulses.
REQ-012 The block SHALL have port i_disel_n, input, 1 bit: DTC clear enable, active 0.
REQ-013 The block SHALL have port i_dtc_ack, input, NUM_CH bits: per-channel DTC transfer-complete strobes.
REQ-014 The block SHALL have port o_os, output, 2*NUM_CH bits: output-select fields, 2 bits per channel, channel k in bits [2k+1:2k].
REQ-015 The block SHALL have port o_adte, output, 1 bit: A/D trigger enable.
REQ-016 The block SHALL have port o_irq, output, 1 bit: interrupt request.

Function
REQ-017 CTRL SHALL map [2*NUM_CH-1:0] to OS and [2*NUM_CH] to ADTE; it SHALL be plain read/write, loaded when i_wren=1 and i_addr=0.
REQ-018 STAT SHALL map [NUM_CH-1:0] to CMF[k] and [NUM_CH] to OVF; IE and OVR SHALL use the same bit positions.
REQ-019 IE SHALL be plain read/write, loaded when i_wren=1 and i_addr=2.
REQ-020 Unmapped bits SHALL read 0, and writes to them SHALL have no effect.
REQ-021 A flag SHALL set on the clock edge following a cycle where its event input (i_cm[k] or i_overflow) is 1.
REQ-022 A flag SHALL clear when i_wren=1, i_addr=1 and the corresponding i_wdata bit is 1 (write-1-to-clear); writing 0 SHALL leave the flag unchanged.
REQ-023 CMF[k] SHALL also clear when i_disel_n=0 and i_dtc_ack[k]=1; when i_disel_n=1, i_dtc_ack SHALL be ignored.
REQ-024 When an event and a clear (bus or DTC) occur in the same cycle, the event SHALL win: the flag ends at 1 and OVR does not set.
REQ-025 OVR[b] SHALL set when event b occurs while flag b is 1 and flag b is not being cleared in that cycle.
REQ-026 OVR SHALL be write-1-to-clear at i_addr=3; in a simultaneous set and clear, the set SHALL win.
REQ-027 irq_lvl SHALL be defined as the OR over b of (STAT[b] AND IE[b]), computed from registered state.
REQ-028 When IRQ_PULSE=0, o_irq SHALL equal irq_lvl.
REQ-029 When IRQ_PULSE=1, o_irq SHALL be irq_lvl AND NOT irq_lvl_q, where irq_lvl_q is irq_lvl delayed one cycle, giving one cycle high per rising edge.
REQ-030 In pulse mode, further flags setting while irq_lvl is already 1 SHALL NOT generate a new pulse.
REQ-031 o_rdata SHALL reflect register state before the current cycle's write, with zero-cycle read latency.
REQ-032 o_os and o_adte SHALL be driven directly from the CTRL register.

Reset
REQ-033 While i_rst_n=0, CTRL, STAT, IE, OVR and irq_lvl_q SHALL be 0 asynchronously.
REQ-034 During reset, o_os SHALL be 0, o_adte SHALL be 0 and o_irq SHALL be 0.
REQ-035 Events arriving during reset SHALL be discarded.
REQ-036 Reset asserted mid-operation SHALL clear all pending flags and overruns immediately, without waiting for a clock edge.

Verification (NUM_CH=4, DATA_W=16)
REQ-037 Reset test: after reset, reads at addr 0..3 -> 0x0000, and o_irq=0.
REQ-038 CTRL test: write 0x01FF to addr 0 -> o_os=0xFF, o_adte=1, and a read of addr 0 returns 0x01FF.
REQ-039 Flag set/clear test: pulse i_cm[1] -> STAT=0x0002 next cycle; write 0x0002 to addr 1 -> STAT=0x0000; a separate write of 0x0000 leaves STAT unchanged.
REQ-040 Simultaneous event/clear test: i_cm[2]=1 in the same cycle as writing 0x0004 to addr 1 -> STAT=0x0004 and OVR=0x0000.
REQ-041 Overrun test: pulse i_cm[1] twice, two cycles apart -> OVR=0x0002; write 0x0002 to addr 3 -> OVR=0x0000.
REQ-042 Interrupt/DTC test: set IE=0x0010 and pulse i_overflow -> o_irq=1 held (IRQ_PULSE=0) or o_irq=1 for exactly one cycle (IRQ_PULSE=1); separately, i_disel_n=0 with i_dtc_ack[0]=1 clears CMF[0], and i_disel_n=1 does not.

Source files
------------

// File: rtl/tcsr_multi.sv
// Multi-channel timer control/status register block: CTRL/STAT/IE/OVR
// registers with write-1-to-clear flags, DTC clear path and level or
// pulse interrupt output.
module tcsr_multi #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned IRQ_PULSE = 0
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst_n,
  input  logic                  i_wren,
  input  logic [1:0]            i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata,
  input  logic                  i_overflow,
  input  logic [NUM_CH-1:0]     i_cm,
  input  logic                  i_disel_n,
  input  logic [NUM_CH-1:0]     i_dtc_ack,
  output logic [2*NUM_CH-1:0]   o_os,
  output logic                  o_adte,
  output logic                  o_irq
);

  // Flag vector width (CMF per channel plus OVF) and CTRL width (OS fields plus ADTE).
  localparam int unsigned FLAG_W = NUM_CH + 1;
  localparam int unsigned CTRL_W = 2 * NUM_CH + 1;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_IE   = 2'd2;
  localparam logic [1:0] ADDR_OVR  = 2'd3;

  // Reject configurations whose registers do not fit the bus.
  generate
    if (NUM_CH < 1 || NUM_CH > 7 || CTRL_W > DATA_W) begin : g_bad_cfg
      $error("tcsr_multi: illegal NUM_CH/DATA_W combination");
    end
  endgenerate

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [FLAG_W-1:0] stat_q, stat_d;
  logic [FLAG_W-1:0] ie_q, ie_d;
  logic [FLAG_W-1:0] ovr_q, ovr_d;
  logic              irq_lvl, irq_lvl_q;

  logic [FLAG_W-1:0] ev;
  logic [FLAG_W-1:0] stat_clr;
  logic [FLAG_W-1:0] ovr_clr;

  // Upper write-data bits have no storage behind them.
  logic unused_wdata;
  assign unused_wdata = ^i_wdata;

  // Next-state: events beat clears; overrun only when the flag survives the cycle.
  always_comb begin
    ev       = {i_overflow, i_cm};
    stat_clr = '0;
    ovr_clr  = '0;
    ctrl_d   = ctrl_q;
    ie_d     = ie_q;
    if (i_wren && i_addr == ADDR_STAT) stat_clr = i_wdata[FLAG_W-1:0];
    if (!i_disel_n)                    stat_clr = stat_clr | {1'b0, i_dtc_ack};
    if (i_wren && i_addr == ADDR_OVR)  ovr_clr  = i_wdata[FLAG_W-1:0];
    if (i_wren && i_addr == ADDR_CTRL) ctrl_d   = i_wdata[CTRL_W-1:0];
    if (i_wren && i_addr == ADDR_IE)   ie_d     = i_wdata[FLAG_W-1:0];
    stat_d = ev | (stat_q & ~stat_clr);
    ovr_d  = (ev & stat_q & ~stat_clr) | (ovr_q & ~ovr_clr);
  end

  // Register state with asynchronous clear.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q    <= '0;
      stat_q    <= '0;
      ie_q      <= '0;
      ovr_q     <= '0;
      irq_lvl_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      stat_q    <= stat_d;
      ie_q      <= ie_d;
      ovr_q     <= ovr_d;
      irq_lvl_q <= irq_lvl;
    end
  end

  // Interrupt level from registered state; pulse mode emits only rising edges.
  assign irq_lvl = |(stat_q & ie_q);
  assign o_irq   = (IRQ_PULSE != 0) ? (irq_lvl & ~irq_lvl_q) : irq_lvl;

  assign o_os   = ctrl_q[2*NUM_CH-1:0];
  assign o_adte = ctrl_q[2*NUM_CH];

  // Zero-latency read mux; unmapped bits read as zero.
  always_comb begin
    o_rdata = '0;
    case (i_addr)
      ADDR_CTRL: o_rdata = DATA_W'(ctrl_q);
      ADDR_STAT: o_rdata = DATA_W'(stat_q);
      ADDR_IE:   o_rdata = DATA_W'(ie_q);
      default:   o_rdata = DATA_W'(ovr_q);
    endcase
  end

endmodule

// File: tb/tb_tcsr_multi.sv
// Directed bench for tcsr_multi: level-mode instance plus a pulse-mode
// instance sharing the same stimulus.
module tb_tcsr_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wren = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] wdata = 16'h0;
  logic        overflow = 1'b0;
  logic [3:0]  cm = 4'h0;
  logic        disel_n = 1'b1;
  logic [3:0]  dtc_ack = 4'h0;

  logic [15:0] rdata, rdata_p;
  logic [7:0]  os, os_p;
  logic        adte, adte_p;
  logic        irq, irq_p;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  tcsr_multi #(.NUM_CH(4), .DATA_W(16), .IRQ_PULSE(0)) dut (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_wren(wren), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .i_overflow(overflow), .i_cm(cm),
    .i_disel_n(disel_n), .i_dtc_ack(dtc_ack), .o_os(os), .o_adte(adte),
    .o_irq(irq)
  );

  tcsr_multi #(.NUM_CH(4), .DATA_W(16), .IRQ_PULSE(1)) dut_p (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_wren(wren), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata_p), .i_overflow(overflow), .i_cm(cm),
    .i_disel_n(disel_n), .i_dtc_ack(dtc_ack), .o_os(os_p), .o_adte(adte_p),
    .o_irq(irq_p)
  );

  // One bus write, leaving the bench 1 time unit after the capturing edge.
  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    wren = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wren = 1'b0; wdata = 16'h0;
  endtask

  // One-cycle event pulse.
  task automatic ev_pulse(input logic [3:0] c, input logic o);
    cm = c; overflow = o;
    @(posedge clk); #1;
    cm = 4'h0; overflow = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cm = 4'hF; overflow = 1'b1;
    idle(3);
    total++; if (irq !== 1'b0 || irq_p !== 1'b0) $display("FAIL rst_irq_during got %b/%b exp 0/0", irq, irq_p); else pass_cnt++;
    total++; if (os !== 8'h00 || adte !== 1'b0) $display("FAIL rst_ctrl_during got os=%h adte=%b exp 00/0", os, adte); else pass_cnt++;
    cm = 4'h0; overflow = 1'b0;
    rst_n = 1'b1;
    idle(1);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      total++; if (rdata !== 16'h0000) $display("FAIL rst_read addr=%0d got %h exp 0000", a, rdata); else pass_cnt++;
    end
    total++; if (irq !== 1'b0) $display("FAIL rst_irq got %b exp 0", irq); else pass_cnt++;
  endtask

  task automatic test_ctrl;
    bus_wr(2'd0, 16'h01FF);
    total++; if (os !== 8'hFF) $display("FAIL ctrl_os got %h exp ff", os); else pass_cnt++;
    total++; if (adte !== 1'b1) $display("FAIL ctrl_adte got %b exp 1", adte); else pass_cnt++;
    addr = 2'd0; #1;
    total++; if (rdata !== 16'h01FF) $display("FAIL ctrl_read got %h exp 01ff", rdata); else pass_cnt++;
    bus_wr(2'd0, 16'hFE56);
    addr = 2'd0; #1;
    total++; if (rdata !== 16'h0056 || os !== 8'h56 || adte !== 1'b0) $display("FAIL ctrl_unmapped got %h exp 0056", rdata); else pass_cnt++;
    bus_wr(2'd0, 16'h0000);
  endtask

  task automatic test_flags;
    ev_pulse(4'h2, 1'b0);
    addr = 2'd1; #1;
    total++; if (rdata !== 16'h0002) $display("FAIL flag_set got %h exp 0002", rdata); else pass_cnt++;
    bus_wr(2'd1, 16'h0002);
    addr = 2'd1; #1;
    total++; if (rdata !== 16'h0000) $display("FAIL flag_w1c got %h exp 0000", rdata); else pass_cnt++;
    ev_pulse(4'h2, 1'b0);
    bus_wr(2'd1, 16'h0000);
    addr = 2'd1; #1;
    total++; if (rdata !== 16'h0002) $display("FAIL flag_w0 got %h exp 0002", rdata); else pass_cnt++;
    bus_wr(2'd1, 16'h001F);
  endtask

  task automatic test_simultaneous;
    cm = 4'h4; wren = 1'b1; addr = 2'd1; wdata = 16'h0004;
    @(posedge clk); #1;
    cm = 4'h0; wren = 1'b0; wdata = 16'h0;
    addr = 2'd1; #1;
    total++; if (rdata !== 16'h0004) $display("FAIL simul_stat got %h exp 0004", rdata); else pass_cnt++;
    addr = 2'd3; #1;
    total++; if (rdata !== 16'h0000) $display("FAIL simul_ovr got %h exp 0000", rdata); else pass_cnt++;
    // Flag already set: event plus clear keeps flag, still no overrun.
    cm = 4'h4; wren = 1'b1; addr = 2'd1; wdata = 16'h0004;
    @(posedge clk); #1;
    cm = 4'h0; wren = 1'b0; wdata = 16'h0;
    addr = 2'd1; #1;
    total++; if (rdata !== 16'h0004) $display("FAIL simul2_stat got %h exp 0004", rdata); else pass_cnt++;
    addr = 2'd3; #1;
    total++; if (rdata !== 16'h0000) $display("FAIL simul2_ovr got %h exp 0000", rdata); else pass_cnt++;
    bus_wr(2'd1, 16'h001F);
  endtask

  task automatic test_overrun;
    ev_pulse(4'h2, 1'b0);
    idle(1);
    ev_pulse(4'h2, 1'b0);
    addr = 2'd3; #1;
    total++; if (rdata !== 16'h0002) $display("FAIL ovr_set got %h exp 0002", rdata); else pass_cnt++;
    bus_wr(2'd3, 16'h0002);
    addr = 2'd3; #1;
    total++; if (rdata !== 16'h0000) $display("FAIL ovr_w1c got %h exp 0000", rdata); else pass_cnt++;
    // Overrun set and OVR clear in the same cycle: set wins.
    cm = 4'h2; wren = 1'b1; addr = 2'd3; wdata = 16'h0002;
    @(posedge clk); #1;
    cm = 4'h0; wren = 1'b0; wdata = 16'h0;
    addr = 2'd3; #1;
    total++; if (rdata !== 16'h0002) $display("FAIL ovr_set_wins got %h exp 0002", rdata); else pass_cnt++;
    // Overflow flag overrun uses bit NUM_CH.
    ev_pulse(4'h0, 1'b1);
    ev_pulse(4'h0, 1'b1);
    addr = 2'd3; #1;
    total++; if (rdata !== 16'h0012) $display("FAIL ovr_ovf got %h exp 0012", rdata); else pass_cnt++;
    bus_wr(2'd3, 16'hFFFF);
    bus_wr(2'd1, 16'hFFFF);
  endtask

  task automatic test_irq;
    bus_wr(2'd2, 16'h0010);
    addr = 2'd2; #1;
    total++; if (rdata !== 16'h0010) $display("FAIL ie_read got %h exp 0010", rdata); else pass_cnt++;
    ev_pulse(4'h1, 1'b0);
    total++; if (irq !== 1'b0 || irq_p !== 1'b0) $display("FAIL irq_masked got %b/%b exp 0/0", irq, irq_p); else pass_cnt++;
    bus_wr(2'd1, 16'h001F);
    bus_wr(2'd2, 16'h0011);
    ev_pulse(4'h0, 1'b1);
    total++; if (irq !== 1'b1 || irq_p !== 1'b1) $display("FAIL irq_rise got %b/%b exp 1/1", irq, irq_p); else pass_cnt++;
    idle(1);
    total++; if (irq !== 1'b1 || irq_p !== 1'b0) $display("FAIL irq_hold got %b/%b exp 1/0", irq, irq_p); else pass_cnt++;
    ev_pulse(4'h1, 1'b0);
    total++; if (irq !== 1'b1 || irq_p !== 1'b0) $display("FAIL irq_no_repulse got %b/%b exp 1/0", irq, irq_p); else pass_cnt++;
    bus_wr(2'd1, 16'h001F);
    total++; if (irq !== 1'b0 || irq_p !== 1'b0) $display("FAIL irq_clear got %b/%b exp 0/0", irq, irq_p); else pass_cnt++;
    idle(1);
    ev_pulse(4'h1, 1'b0);
    total++; if (irq !== 1'b1 || irq_p !== 1'b1) $display("FAIL irq_second_rise got %b/%b exp 1/1", irq, irq_p); else pass_cnt++;
    bus_wr(2'd1, 16'h001F);
    bus_wr(2'd2, 16'h0000);
  endtask

  task automatic test_dtc;
    ev_pulse(4'h1, 1'b0);
    disel_n = 1'b1; dtc_ack = 4'h1;
    idle(1);
    dtc_ack = 4'h0;
    addr = 2'd1; #1;
    total++; if (rdata !== 16'h0001) $display("FAIL dtc_ignored got %h exp 0001", rdata); else pass_cnt++;
    disel_n = 1'b0; dtc_ack = 4'h1;
    idle(1);
    dtc_ack = 4'h0; disel_n = 1'b1;
    addr = 2'd1; #1;
    total++; if (rdata !== 16'h0000) $display("FAIL dtc_clear got %h exp 0000", rdata); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    bus_wr(2'd0, 16'h0155);
    bus_wr(2'd2, 16'h001F);
    ev_pulse(4'h8, 1'b1);
    ev_pulse(4'h8, 1'b0);
    addr = 2'd3; #1;
    total++; if (rdata !== 16'h0008 || irq !== 1'b1) $display("FAIL pre_reset got ovr=%h irq=%b exp 0008/1", rdata, irq); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    addr = 2'd1; #1;
    total++; if (rdata !== 16'h0000) $display("FAIL async_stat got %h exp 0000", rdata); else pass_cnt++;
    addr = 2'd3; #1;
    total++; if (rdata !== 16'h0000) $display("FAIL async_ovr got %h exp 0000", rdata); else pass_cnt++;
    total++; if (irq !== 1'b0 || os !== 8'h00 || adte !== 1'b0) $display("FAIL async_outs got irq=%b os=%h adte=%b exp 0/00/0", irq, os, adte); else pass_cnt++;
    idle(1);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_flags();
    test_simultaneous();
    test_overrun();
    test_irq();
    test_dtc();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
